coin_step_sequencer: RTL

- Upstream command stage for the vending credit counter.
- Synchronises and edge-detects raw coin and vend inputs, then keeps a credit mirror.
- Issues at most one step command per clock to the up/down-by-1-or-2 credit counter:
  - step_down: 0 = up, 1 = down.
  - step_two: 0 = by 1, 1 = by 2.
- Sequences debit, dispense and change return so the counter and the mirror always agree.

---
 rtl/coin_step_sequencer_if.sv | 29 ++
 rtl/coin_step_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/coin_step_sequencer_if.sv
// Raw coin/vend inputs and the step-command / status outputs of the coin step sequencer.
interface coin_step_sequencer_if #(
  parameter int W = 4
);
  logic         coin1_in;
  logic         coin2_in;
  logic         vend_req;
  logic         step_valid;
  logic         step_down;
  logic         step_two;
  logic [W-1:0] credit;
  logic         dispense;
  logic         change_out;
  logic         coin_reject;
  logic         vend_denied;
  logic         busy;

  modport master (
    output coin1_in, coin2_in, vend_req,
    input  step_valid, step_down, step_two, credit,
    input  dispense, change_out, coin_reject, vend_denied, busy
  );

  modport slave (
    input  coin1_in, coin2_in, vend_req,
    output step_valid, step_down, step_two, credit,
    output dispense, change_out, coin_reject, vend_denied, busy
  );
endinterface

// File: rtl/coin_step_sequencer.sv
// Conditions coin/vend inputs, mirrors credit and issues one up/down-by-1-or-2 step per cycle
// to the downstream credit counter while sequencing debit, dispense and change return.
//
// state    | meaning
// IDLE     | accept coins, evaluate vend requests
// DEBIT    | step credit down by PRICE, two units at a time where possible
// DISPENSE | one-cycle product release, no step
// CHANGE   | return remaining credit one unit per cycle
module coin_step_sequencer #(
  parameter int W     = 4,
  parameter int PRICE = 3
) (
  input logic                 clk,
  input logic                 rst,
  coin_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBIT, DISPENSE, CHANGE} state_t;

  localparam logic [W:0]   CMAX    = {1'b0, {W{1'b1}}};
  localparam logic [W:0]   ONE_X   = (W+1)'(1);
  localparam logic [W:0]   TWO_X   = (W+1)'(2);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);
  localparam logic [W-1:0] PRICE_W = W'(PRICE);

  // bit 0 = coin1, bit 1 = coin2, bit 2 = vend
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] hist_q,  hist_d;
  logic [2:0] ev_q,    ev_d;

  state_t       state_q, state_d;
  logic [W-1:0] credit_q, credit_d;
  logic [W-1:0] debit_q, debit_d;

  logic step_valid_q, step_valid_d;
  logic step_down_q,  step_down_d;
  logic step_two_q,   step_two_d;
  logic dispense_q,   dispense_d;
  logic change_out_q, change_out_d;
  logic coin_reject_q, coin_reject_d;
  logic vend_denied_q, vend_denied_d;
  logic busy_q, busy_d;

  logic ev_c1, ev_c2, ev_v;
  logic [W-1:0] step_amt;

  assign ev_c1 = ev_q[0];
  assign ev_c2 = ev_q[1];
  assign ev_v  = ev_q[2];

  // Edge detect is registered so the event lands two edges after the raw level is sampled.
  always_comb begin
    sync1_d = {bus.vend_req, bus.coin2_in, bus.coin1_in};
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    ev_d    = sync2_q & ~hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      hist_q        <= '0;
      ev_q          <= '0;
      state_q       <= IDLE;
      credit_q      <= '0;
      debit_q       <= '0;
      step_valid_q  <= 1'b0;
      step_down_q   <= 1'b0;
      step_two_q    <= 1'b0;
      dispense_q    <= 1'b0;
      change_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_denied_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      ev_q          <= ev_d;
      state_q       <= state_d;
      credit_q      <= credit_d;
      debit_q       <= debit_d;
      step_valid_q  <= step_valid_d;
      step_down_q   <= step_down_d;
      step_two_q    <= step_two_d;
      dispense_q    <= dispense_d;
      change_out_q  <= change_out_d;
      coin_reject_q <= coin_reject_d;
      vend_denied_q <= vend_denied_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    debit_d = debit_q;
    case (state_q)
      IDLE: begin
        if (!ev_c1 && !ev_c2 && ev_v && (credit_q >= PRICE_W)) begin
          debit_d = PRICE_W;
          state_d = DEBIT;
        end
      end
      DEBIT: begin
        debit_d = (debit_q >= TWO) ? (debit_q - TWO) : '0;
        if (debit_d == '0) state_d = DISPENSE;
      end
      DISPENSE: state_d = (credit_q != '0) ? CHANGE : IDLE;
      CHANGE:   if (credit_q == ONE) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    step_valid_d  = 1'b0;
    step_down_d   = 1'b0;
    step_two_d    = 1'b0;
    dispense_d    = 1'b0;
    change_out_d  = 1'b0;
    coin_reject_d = 1'b0;
    vend_denied_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_c2) begin
          if (({1'b0, credit_q} + TWO_X) <= CMAX) begin
            step_valid_d = 1'b1;
            step_two_d   = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
          if (ev_c1) coin_reject_d = 1'b1;
        end else if (ev_c1) begin
          if (({1'b0, credit_q} + ONE_X) <= CMAX) step_valid_d = 1'b1;
          else coin_reject_d = 1'b1;
        end else if (ev_v && (credit_q < PRICE_W)) begin
          vend_denied_d = 1'b1;
        end
      end
      DEBIT: begin
        step_valid_d = 1'b1;
        step_down_d  = 1'b1;
        step_two_d   = (debit_q >= TWO);
      end
      DISPENSE: dispense_d = 1'b1;
      CHANGE: begin
        step_valid_d = 1'b1;
        step_down_d  = 1'b1;
        change_out_d = 1'b1;
      end
      default: ;
    endcase
    if ((state_q != IDLE) && (ev_c1 || ev_c2)) coin_reject_d = 1'b1;
  end

  // Mirror follows the issued command on the same edge the counter sees it.
  always_comb begin
    step_amt = step_two_d ? TWO : ONE;
    credit_d = credit_q;
    if (step_valid_d) credit_d = step_down_d ? (credit_q - step_amt) : (credit_q + step_amt);
    busy_d = (state_d != IDLE);
  end

  assign bus.step_valid  = step_valid_q;
  assign bus.step_down   = step_down_q;
  assign bus.step_two    = step_two_q;
  assign bus.credit      = credit_q;
  assign bus.dispense    = dispense_q;
  assign bus.change_out  = change_out_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.vend_denied = vend_denied_q;
  assign bus.busy        = busy_q;

endmodule
